// File: rtl/sim_run_pkg.sv
// rtl/sim_run_pkg.sv - shared state encoding, widths and saturating-increment helper for run control
package sim_run_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_HOLD  = 3'd1,
        ST_RUN   = 3'd2,
        ST_DRAIN = 3'd3,
        ST_END   = 3'd4
    } run_state_t;

    localparam int EVENT_W = 64;
    localparam int PHASE_W = 32;

    // Increment that sticks at the all-ones value of a width-bit field.
    function automatic logic [63:0] sat_inc(input logic [63:0] value, input int width);
        logic [63:0] max_v;
        max_v = (width >= 64) ? 64'hFFFF_FFFF_FFFF_FFFF : ((64'd1 << width) - 64'd1);
        return (value >= max_v) ? max_v : (value + 64'd1);
    endfunction

endpackage

// File: rtl/sim_sat_counter.sv
// rtl/sim_sat_counter.sv - parameterised saturating counter with synchronous clear and enable
module sim_sat_counter
    import sim_run_pkg::*;
#(
    parameter int W = 32
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         clr_i,
    input  logic         en_i,
    output logic [W-1:0] cnt_o
);

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cnt_o <= '0;
        end else if (clr_i) begin
            cnt_o <= '0;
        end else if (en_i) begin
            cnt_o <= W'(sat_inc(64'(cnt_o), W));
        end
    end

endmodule

// File: rtl/sim_run_ctrl.sv
// rtl/sim_run_ctrl.sv - run-control FSM: reset hold, cycle budget, drain and end status for the sim top
module sim_run_ctrl
    import sim_run_pkg::*;
#(
    parameter int RESET_CYCLES = 11,
    parameter int MAX_CYCLES   = 1000,
    parameter int DRAIN_CYCLES = 16,
    parameter int CNT_W        = 32
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic               start_i,
    input  logic               stop_req_i,
    input  logic               event_i,
    output logic               run_reset_n_o,
    output logic               running_o,
    output logic               done_o,
    output logic               timeout_o,
    output logic [CNT_W-1:0]   cycle_cnt_o,
    output logic [EVENT_W-1:0] event_cnt_o,
    output logic [2:0]         state_o
);

    localparam logic [PHASE_W-1:0] HOLD_LAST  = PHASE_W'(RESET_CYCLES - 1);
    localparam logic [PHASE_W-1:0] RUN_LAST   = PHASE_W'(MAX_CYCLES - 1);
    localparam logic [PHASE_W-1:0] DRAIN_LAST = PHASE_W'(DRAIN_CYCLES - 1);

    run_state_t         state_q;
    run_state_t         state_d;
    logic               phase_clr;
    logic               phase_en;
    logic               done_d;
    logic               timeout_d;
    logic [PHASE_W-1:0] phase;

    // The budget is judged on the wide phase counter so a narrow cycle_cnt_o
    // can saturate without hiding the timeout.
    always_comb begin
        state_d   = state_q;
        phase_clr = 1'b0;
        phase_en  = 1'b0;
        done_d    = done_o;
        timeout_d = timeout_o;
        case (state_q)
            ST_IDLE: begin
                if (start_i) begin
                    state_d   = ST_HOLD;
                    phase_clr = 1'b1;
                end
            end
            ST_HOLD: begin
                if (phase == HOLD_LAST) begin
                    state_d   = ST_RUN;
                    phase_clr = 1'b1;
                end else begin
                    phase_en = 1'b1;
                end
            end
            ST_RUN: begin
                if (stop_req_i) begin
                    phase_clr = 1'b1;
                    if (DRAIN_CYCLES == 0) begin
                        state_d = ST_END;
                        done_d  = 1'b1;
                    end else begin
                        state_d = ST_DRAIN;
                    end
                end else if (phase == RUN_LAST) begin
                    state_d   = ST_END;
                    timeout_d = 1'b1;
                end else begin
                    phase_en = 1'b1;
                end
            end
            ST_DRAIN: begin
                if (phase == DRAIN_LAST) begin
                    state_d = ST_END;
                    done_d  = 1'b1;
                end else begin
                    phase_en = 1'b1;
                end
            end
            default: begin
            end
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q       <= ST_IDLE;
            run_reset_n_o <= 1'b0;
            running_o     <= 1'b0;
            done_o        <= 1'b0;
            timeout_o     <= 1'b0;
        end else begin
            state_q       <= state_d;
            run_reset_n_o <= state_d inside {ST_RUN, ST_DRAIN, ST_END};
            running_o     <= state_d inside {ST_RUN, ST_DRAIN};
            done_o        <= done_d;
            timeout_o     <= timeout_d;
        end
    end

    assign state_o = state_q;

    sim_sat_counter #(.W(PHASE_W)) u_phase_cnt (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .clr_i (phase_clr),
        .en_i  (phase_en),
        .cnt_o (phase)
    );

    sim_sat_counter #(.W(CNT_W)) u_cycle_cnt (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .clr_i (1'b0),
        .en_i  (running_o),
        .cnt_o (cycle_cnt_o)
    );

    sim_sat_counter #(.W(EVENT_W)) u_event_cnt (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .clr_i (1'b0),
        .en_i  (event_i & running_o),
        .cnt_o (event_cnt_o)
    );

endmodule

// File: tb/tb_sim_run_ctrl.sv
// tb/tb_sim_run_ctrl.sv - scoreboard bench for sim_run_ctrl with randomised stop points and event strobes
module tb_sim_run_ctrl;
    import sim_run_pkg::*;

    localparam int R   = 11;
    localparam int MAX = 1000;
    localparam int D   = 16;
    localparam int RS  = 2;
    localparam int MS  = 20;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic        start = 1'b0, stop_req = 1'b0, ev = 1'b0;
    logic        rr_n, running, done, tmo;
    logic [31:0] cyc;
    logic [63:0] evc;
    logic [2:0]  st;

    logic        start_s = 1'b0, stop_s = 1'b0, ev_s = 1'b0;
    logic        rr_n_s, running_s, done_s, tmo_s;
    logic [3:0]  cyc_s;
    logic [63:0] evc_s;
    logic [2:0]  st_s;

    sim_run_ctrl dut (
        .clk_i(clk), .rst_i(rst), .start_i(start), .stop_req_i(stop_req), .event_i(ev),
        .run_reset_n_o(rr_n), .running_o(running), .done_o(done), .timeout_o(tmo),
        .cycle_cnt_o(cyc), .event_cnt_o(evc), .state_o(st)
    );

    sim_run_ctrl #(.RESET_CYCLES(RS), .MAX_CYCLES(MS), .DRAIN_CYCLES(0), .CNT_W(4)) dut_s (
        .clk_i(clk), .rst_i(rst), .start_i(start_s), .stop_req_i(stop_s), .event_i(ev_s),
        .run_reset_n_o(rr_n_s), .running_o(running_s), .done_o(done_s), .timeout_o(tmo_s),
        .cycle_cnt_o(cyc_s), .event_cnt_o(evc_s), .state_o(st_s)
    );

    typedef struct {
        logic        done;
        logic        tmo;
        logic [63:0] cyc;
        logic [63:0] evc;
    } exp_t;

    exp_t exp_q[$];
    int   total = 0;
    int   bad   = 0;
    bit   seen  = 1'b0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %0d want %0d", name, act, req);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        tick();
    endtask

    task automatic monitor();
        exp_t e;
        forever begin
            @(negedge clk);
            if (rst) begin
                seen = 1'b0;
            end else if ((done || tmo) && !seen) begin
                seen = 1'b1;
                if (exp_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected end: done=%0d timeout=%0d with no run expected", done, tmo);
                end else begin
                    e = exp_q.pop_front();
                    chk("end done", 64'(done), 64'(e.done));
                    chk("end timeout", 64'(tmo), 64'(e.tmo));
                    chk("end cycle_cnt", 64'(cyc), e.cyc);
                    chk("end event_cnt", evc, e.evc);
                end
            end
        end
    endtask

    // s < 0: no stop request (budget run); s >= 0: stop on that 0-based RUN cycle.
    // abort_at >= 0: assert rst that many cycles into DRAIN, between clock edges.
    task automatic do_run(input int s, input int abort_at);
        bit          stop;
        int          nrun;
        int          last;
        logic [63:0] ev_exp;
        bit          evpat[$];
        stop   = (s >= 0);
        nrun   = stop ? s + 1 : MAX;
        last   = R + nrun + (stop ? D : 0);
        ev_exp = 0;
        for (int i = -10; i <= last + 3; i++) begin
            evpat.push_back($urandom_range(0, 3) != 0);
            if (evpat[i + 10] && i >= R + 1 && i <= last) ev_exp++;
        end
        if (abort_at < 0)
            exp_q.push_back('{stop, !stop, 64'(nrun + (stop ? D : 0)), ev_exp});
        for (int i = -10; i < 0; i++) begin
            ev = evpat[i + 10];
            tick();
        end
        start = 1'b1;
        ev    = evpat[10];
        tick();
        start = 1'b0;
        for (int i = 1; i <= last + 3; i++) begin
            ev = evpat[i + 10];
            if (i <= R)
                stop_req = 1'($urandom_range(0, 1));
            else
                stop_req = stop && (i == R + 1 + s || (i > R + 1 + s && $urandom_range(0, 1) == 1));
            start = (i > last) ? 1'($urandom_range(0, 1)) : 1'b0;
            tick();
            if (i == R - 1) begin
                chk("hold run_reset_n", 64'(rr_n), 0);
                chk("hold state", 64'(st), 1);
            end
            if (i == R) begin
                chk("run run_reset_n", 64'(rr_n), 1);
                chk("run state", 64'(st), 2);
            end
            if (abort_at >= 0 && i == R + nrun + abort_at) begin
                #2 rst = 1'b1;
                #1;
                chk("abort outputs", {rr_n, running, done, tmo, st}, 0);
                chk("abort cycle_cnt", 64'(cyc), 0);
                chk("abort event_cnt", evc, 0);
                start = 1'b0;
                stop_req = 1'b0;
                ev = 1'b0;
                tick();
                rst = 1'b0;
                tick();
                return;
            end
        end
        start    = 1'b0;
        stop_req = 1'b0;
        ev       = 1'b0;
        chk("end reached in budget", 64'(exp_q.size()), 0);
        chk("frozen cycle_cnt", 64'(cyc), 64'(nrun + (stop ? D : 0)));
        chk("frozen state", 64'(st), 4);
        chk("frozen event_cnt", evc, ev_exp);
        do_reset();
    endtask

    initial begin
        fork
            monitor();
        join_none
        rst = 1'b1;
        tick();
        tick();
        chk("reset state", 64'(st), 0);
        chk("reset outputs", {rr_n, running, done, tmo}, 0);
        chk("reset cycle_cnt", 64'(cyc), 0);
        chk("reset event_cnt", evc, 0);
        rst = 1'b0;
        tick();

        do_run(-1, -1);
        do_run(200, -1);
        do_run(MAX - 1, -1);
        do_run(0, -1);
        for (int k = 0; k < 3; k++) do_run(int'($urandom_range(0, MAX - 2)), -1);
        do_run(50, 7);
        do_run(int'($urandom_range(0, 300)), -1);

        ev_s    = 1'b1;
        start_s = 1'b1;
        tick();
        start_s = 1'b0;
        for (int i = 1; i <= RS + MS; i++) begin
            tick();
            if (i == RS + MS - 1) begin
                chk("small pre timeout", 64'(tmo_s), 0);
                chk("small pre state", 64'(st_s), 2);
                chk("small saturated cnt", 64'(cyc_s), 15);
            end
            if (i == RS + MS) begin
                chk("small timeout", 64'(tmo_s), 1);
                chk("small done", 64'(done_s), 0);
                chk("small end cnt", 64'(cyc_s), 15);
                chk("small end state", 64'(st_s), 4);
                chk("small event_cnt", evc_s, MS);
            end
        end
        start_s = 1'b1;
        tick();
        start_s = 1'b0;
        tick();
        chk("small start in end state", 64'(st_s), 4);
        chk("small start in end rr_n", 64'(rr_n_s), 1);
        chk("small start in end cnt", 64'(cyc_s), 15);
        ev_s = 1'b0;
        do_reset();

        start_s = 1'b1;
        tick();
        start_s = 1'b0;
        for (int i = 1; i <= RS + 3; i++) begin
            stop_s = (i == RS + 3);
            tick();
        end
        stop_s = 1'b0;
        chk("nodrain done", 64'(done_s), 1);
        chk("nodrain timeout", 64'(tmo_s), 0);
        chk("nodrain state", 64'(st_s), 4);
        chk("nodrain cnt", 64'(cyc_s), 3);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
